// File: rtl/prog_launcher_if.sv
// Run-handshake wires between the program launcher (master) and the processor core (slave).
interface prog_launcher_if;
  logic DutReset;
  logic DutStart;
  logic DutAck;

  modport master (output DutReset, output DutStart, input DutAck);
  modport slave  (input DutReset, input DutStart, output DutAck);
endinterface

// File: rtl/prog_launcher.sv
// Host-side launcher for the core's Reset/Start/Ack run handshake: resets the core, runs
// NUM_PROGS programs back to back and reports each program's cycle count or timeout.
module prog_launcher #(
  parameter int  NUM_PROGS = 3,
  parameter int  CYC_W     = 16,
  parameter int  RST_CYC   = 4,
  parameter int  START_CYC = 2,
  parameter int  TIMEOUT   = 60000,
  localparam int IDX_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Go,
  prog_launcher_if.master  dut,
  output logic [IDX_W-1:0] ProgIdx,
  output logic [CYC_W-1:0] CycleCount,
  output logic             ResultValid,
  output logic             TimedOut,
  output logic             Busy,
  output logic             Done
);

  localparam int PH_MAX = (RST_CYC > START_CYC) ? RST_CYC : START_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e           state_q;
  logic             ack_q;
  logic             dut_reset_q;
  logic             dut_start_q;
  logic [PH_W-1:0]  ph_q;
  logic [CYC_W-1:0] run_cnt_q;
  logic [CYC_W-1:0] run_cnt_d;
  logic             last_prog_s;

  // Candidate run count for a cycle in which the core has not yet acknowledged.
  always_comb begin
    run_cnt_d = run_cnt_q + CYC_W'(1);
  end

  assign last_prog_s  = (ProgIdx == IDX_W'(NUM_PROGS - 1));
  assign dut.DutReset = dut_reset_q;
  assign dut.DutStart = dut_start_q;

  // Sequencer FSM; all handshake and report outputs are registered here.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      dut_reset_q <= 1'b1;
      dut_start_q <= 1'b0;
      ph_q        <= {PH_W{1'b0}};
      run_cnt_q   <= {CYC_W{1'b0}};
      ProgIdx     <= {IDX_W{1'b0}};
      CycleCount  <= {CYC_W{1'b0}};
      ResultValid <= 1'b0;
      TimedOut    <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
    end else begin
      ack_q       <= dut.DutAck;
      ResultValid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Go) begin
            state_q <= S_RST;
            ph_q    <= {PH_W{1'b0}};
            Busy    <= 1'b1;
          end
        end
        S_RST: begin
          if (ph_q == PH_W'(RST_CYC)) begin
            state_q     <= S_START;
            ProgIdx     <= {IDX_W{1'b0}};
            dut_reset_q <= 1'b0;
            dut_start_q <= 1'b1;
            ph_q        <= {PH_W{1'b0}};
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        // A stale Ack from the previous halt may still be high here, so ack_q is not looked at.
        S_START: begin
          if (ph_q == PH_W'(START_CYC - 1)) begin
            state_q     <= S_RUN;
            dut_start_q <= 1'b0;
            run_cnt_q   <= {CYC_W{1'b0}};
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        S_RUN: begin
          if (ack_q) begin
            state_q     <= S_REPORT;
            CycleCount  <= run_cnt_q;
            ResultValid <= 1'b1;
          end else if (run_cnt_q == CYC_W'(TIMEOUT - 1)) begin
            state_q     <= S_REPORT;
            CycleCount  <= CYC_W'(TIMEOUT);
            ResultValid <= 1'b1;
            TimedOut    <= 1'b1;
          end else begin
            run_cnt_q <= run_cnt_d;
          end
        end
        S_REPORT: begin
          if (TimedOut || last_prog_s) begin
            state_q <= S_DONE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
          end else begin
            state_q     <= S_START;
            ProgIdx     <= ProgIdx + IDX_W'(1);
            dut_start_q <= 1'b1;
            ph_q        <= {PH_W{1'b0}};
          end
        end
        // The core is left halted out of reset so its Ack stays observable.
        S_DONE: begin
          if (Go) begin
            state_q     <= S_RST;
            ph_q        <= {PH_W{1'b0}};
            dut_reset_q <= 1'b1;
            TimedOut    <= 1'b0;
            Done        <= 1'b0;
            Busy        <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          dut_reset_q <= 1'b1;
          dut_start_q <= 1'b0;
          Busy        <= 1'b0;
          Done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_launcher.sv
// Randomized bench for prog_launcher: a sequence-level timeline model checked every cycle,
// a small core model answering Start with Ack after a programmed delay, and directed scenarios.
module tb_prog_launcher;

  localparam int NP = 3;
  localparam int RC = 4;
  localparam int SC = 2;
  localparam int TO = 50;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Go;
  logic [1:0]  ProgIdx;
  logic [15:0] CycleCount;
  logic        ResultValid, TimedOut, Busy, Done;

  prog_launcher_if dut_if ();

  prog_launcher #(
    .NUM_PROGS(NP), .CYC_W(16), .RST_CYC(RC), .START_CYC(SC), .TIMEOUT(TO)
  ) dut_u (
    .Clk(Clk), .Reset_n(Reset_n), .Go(Go), .dut(dut_if),
    .ProgIdx(ProgIdx), .CycleCount(CycleCount), .ResultValid(ResultValid),
    .TimedOut(TimedOut), .Busy(Busy), .Done(Done)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Core run lengths per program (cycles after Start falls until Ack rises).
  int len_tab [NP];

  // Sequence model: edge index since reset and the planned timeline of the current run.
  int ek = 0;
  bit pv = 1'b0;
  int st [NP];
  int rp [NP];
  int cn [NP];
  bit tof [NP];
  int np = 0;
  int de = 0;
  int prev_idx = 0;
  int prev_cc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic make_plan(input int n);
    int e;
    if (pv) begin
      prev_idx = np - 1;
      prev_cc  = cn[np-1];
    end
    pv = 1'b1;
    np = 0;
    e  = n + RC + 1;
    for (int p = 0; p < NP; p++) begin
      st[p] = e;
      if (len_tab[p] + 1 <= TO - 1) begin
        rp[p] = e + SC + len_tab[p] + 2;
        cn[p] = len_tab[p] + 1;
        tof[p] = 1'b0;
      end else begin
        rp[p] = e + SC + TO;
        cn[p] = TO;
        tof[p] = 1'b1;
      end
      np = p + 1;
      e  = rp[p] + 1;
      if (tof[p]) break;
    end
    de = e;
  endtask

  // Model step on every clock edge, or immediate reset.
  initial begin
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        ek = 0; pv = 1'b0; prev_idx = 0; prev_cc = 0;
      end else begin
        ek++;
        if (Go && (!pv || ek > de)) make_plan(ek);
      end
    end
  end

  task automatic compare();
    int e_res, e_st, e_rv, e_to, e_busy, e_done, e_idx, e_cc;
    if (!Reset_n || !pv) begin
      e_res = 1; e_st = 0; e_rv = 0; e_to = 0; e_busy = 0; e_done = 0; e_idx = 0; e_cc = 0;
    end else begin
      e_res = (ek < st[0]) ? 1 : 0;
      e_st = 0; e_rv = 0; e_to = 0; e_idx = prev_idx; e_cc = prev_cc;
      for (int p = 0; p < np; p++) begin
        if (ek >= st[p] && ek < st[p] + SC) e_st = 1;
        if (ek == rp[p]) e_rv = 1;
        if (ek >= rp[p]) begin e_cc = cn[p]; e_to = tof[p] ? 1 : 0; end
        if (ek >= st[p]) e_idx = p;
      end
      e_busy = (ek < de) ? 1 : 0;
      e_done = (ek >= de) ? 1 : 0;
    end
    chk("cyc_DutReset", dut_if.DutReset, e_res);
    chk("cyc_DutStart", dut_if.DutStart, e_st);
    chk("cyc_ResultValid", ResultValid, e_rv);
    chk("cyc_TimedOut", TimedOut, e_to);
    chk("cyc_Busy", Busy, e_busy);
    chk("cyc_Done", Done, e_done);
    chk("cyc_ProgIdx", ProgIdx, e_idx);
    chk("cyc_CycleCount", CycleCount, e_cc);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge Clk);
      compare();
    end
  end

  // Core model: Start clears Ack and arms; Ack rises len_tab cycles after Start falls.
  bit seen_rst = 1'b1, seen_start = 1'b0, prev_seen_start = 1'b0, armed = 1'b0, core_ack = 1'b0;
  int ccnt = 0, core_prog = -1;
  initial begin
    forever begin
      @(posedge Clk);
      if (seen_rst) begin
        core_ack = 1'b0; armed = 1'b0; core_prog = -1;
      end else if (seen_start) begin
        if (!prev_seen_start) core_prog++;
        core_ack = 1'b0; armed = 1'b1; ccnt = 0;
      end else if (armed) begin
        ccnt++;
        if (core_prog >= 0 && core_prog < NP && ccnt == len_tab[core_prog]) begin
          core_ack = 1'b1; armed = 1'b0;
        end
      end
      prev_seen_start = seen_start;
      #1;
      dut_if.DutAck = core_ack;
      seen_rst   = dut_if.DutReset;
      seen_start = dut_if.DutStart;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_start(input string name);
    int seen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (dut_if.DutStart) begin seen = i; break; end
    end
    chk(name, seen, RC + 1);
  endtask

  task automatic wait_result(input string name, input int e_cc, input int e_idx, input int e_to);
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (ResultValid) break;
    end
    chk({name, "_rv"}, ResultValid, 1);
    chk({name, "_cc"}, CycleCount, e_cc);
    chk({name, "_idx"}, ProgIdx, e_idx);
    chk({name, "_to"}, TimedOut, e_to);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 800; i++) begin
      if (Done) break;
      tick(1);
    end
    chk(name, Done, 1);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_DutReset"}, dut_if.DutReset, 1);
    chk({name, "_DutStart"}, dut_if.DutStart, 0);
    chk({name, "_ProgIdx"}, ProgIdx, 0);
    chk({name, "_CycleCount"}, CycleCount, 0);
    chk({name, "_ResultValid"}, ResultValid, 0);
    chk({name, "_TimedOut"}, TimedOut, 0);
    chk({name, "_Busy"}, Busy, 0);
    chk({name, "_Done"}, Done, 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by randomized sequences.
  initial begin
    int starts;
    int pulse_at;
    Reset_n = 1'b0; Go = 1'b0; dut_if.DutAck = 1'b0;
    len_tab = '{10, 20, 30};
    tick(3);
    chk_reset_vals("por");
    Reset_n = 1'b1;
    tick(3);
    chk("idle_DutReset", dut_if.DutReset, 1);

    // Three programs acking after 10/20/30 cycles; Go pulsed mid-RUN is ignored.
    Go = 1'b1; tick(1); Go = 1'b0;
    chk("model_cnt0", cn[0], 11);
    chk("model_cnt2", cn[2], 31);
    chk("model_np", np, 3);
    wait_start("lat_seq1");
    tick(4);
    Go = 1'b1; tick(1); Go = 1'b0;
    chk("go_in_run_busy", Busy, 1);
    wait_result("s1_p0", 11, 0, 0);
    wait_result("s1_p1", 21, 1, 0);
    wait_result("s1_p2", 31, 2, 0);
    tick(1);
    chk("s1_done", Done, 1);
    chk("s1_busy", Busy, 0);
    chk("s1_to", TimedOut, 0);

    // Program 1 never acks: timeout, stop with ProgIdx=1, program 2 never started.
    len_tab = '{20, 1000, 5};
    Go = 1'b1; tick(1); Go = 1'b0;
    chk("model_to_np", np, 2);
    wait_result("s3_p0", 21, 0, 0);
    wait_result("s3_p1", 50, 1, 1);
    tick(1);
    chk("s3_done", Done, 1);
    chk("s3_to_sticky", TimedOut, 1);
    chk("s3_idx", ProgIdx, 1);
    starts = 0;
    repeat (20) begin
      tick(1);
      if (dut_if.DutStart) starts++;
    end
    chk("s3_no_prog2", starts, 0);

    // Go held from DONE: restart clears TimedOut; Ack on the exact timeout cycle wins.
    len_tab = '{48, 5, 7};
    Go = 1'b1; tick(1);
    chk("s6_busy", Busy, 1);
    chk("s6_to_clr", TimedOut, 0);
    chk("s6_done_clr", Done, 0);
    chk("s6_DutReset", dut_if.DutReset, 1);
    wait_result("s6_p0", 49, 0, 0);
    wait_result("s6_p1", 6, 1, 0);
    wait_result("s6_p2", 8, 2, 0);
    tick(1);
    chk("held_go_done", Done, 1);
    tick(1);
    chk("held_go_restart", Busy, 1);
    chk("held_go_done_clr", Done, 0);
    Go = 1'b0;
    wait_start("lat_restart");

    // Asynchronous reset pulse mid-RUN.
    tick(4);
    Reset_n = 1'b0;
    #1;
    chk_reset_vals("midrun_rst");
    tick(1);
    Reset_n = 1'b1;
    tick(2);
    chk("post_rst_DutReset", dut_if.DutReset, 1);
    Go = 1'b1; tick(1); Go = 1'b0;
    wait_start("lat_after_rst");
    chk("rst_restart_idx", ProgIdx, 0);
    wait_done("s4_done");

    // Random run lengths (some past the timeout) with stray Go pulses while busy.
    for (int it = 0; it < 10; it++) begin
      Go = 1'b0; tick(1);
      for (int p = 0; p < NP; p++) len_tab[p] = $urandom_range(1, 55);
      Go = 1'b1; tick(1); Go = 1'b0;
      pulse_at = $urandom_range(2, 15);
      for (int j = 0; j < 16; j++) begin
        Go = (j == pulse_at) ? 1'b1 : 1'b0;
        tick(1);
      end
      Go = 1'b0;
      wait_done("rnd_done");
    end
    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
